// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with leading-zero suppression, per-digit
// decimal points and whole-display blink. All outputs are registered.
module seg_scan_display #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned BLK_W  = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    logic [PRE_W-1:0]  prescaler;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data_reg;
    logic [DIGITS-1:0] dp_reg;
    logic [BLK_W-1:0]  blink_cnt;
    logic              phase;

    logic              tick;
    logic              frame_wrap;
    logic [3:0]        nib_sel;
    logic              dp_sel;
    logic              lz_sel;
    logic              zero_run;
    logic [6:0]        seg_code;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [DIGITS-1:0] an_next;

    assign tick       = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign frame_wrap = tick && (idx == IDX_W'(DIGITS - 1));

    // Scan timing, data capture and blink phase
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            idx       <= '0;
            data_reg  <= '0;
            dp_reg    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            if (tick) begin
                idx <= frame_wrap ? '0 : idx + IDX_W'(1);
            end
            if (load) begin
                data_reg <= digits_in;
                dp_reg   <= dp_in;
            end
            if (!blink_en) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (frame_wrap) begin
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Walk from the top digit down: a digit is a leading zero while every
    // nibble at or above it is zero. Digit 0 is never suppressed.
    always_comb begin
        nib_sel  = 4'h0;
        dp_sel   = 1'b0;
        lz_sel   = 1'b0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (data_reg[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                nib_sel = data_reg[4*i +: 4];
                dp_sel  = dp_reg[i];
                lz_sel  = zero_run && (i != 0);
            end
        end
    end

    always_comb begin
        seg_code = SEG_BLANK;
        case (nib_sel)
            4'h0: seg_code = 7'h40;
            4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;
            4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;
            4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;
            4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h46;
            4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;
            4'hF: seg_code = 7'h0E;
            default: seg_code = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        an_next  = '1;
        if (!(blink_en && phase)) begin
            an_next = ~(DIGITS'(1) << idx);
            if (!(blank_lz && lz_sel)) begin
                seg_next = seg_code;
                dp_next  = ~dp_sel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            dp_n       <= dp_next;
            an_n       <= an_next;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameters (name, default, meaning):
- DIGITS, 4: number of multiplexed digits, legal range 2..8.
- SCAN_DIV, 50000: clock cycles per digit slot, minimum 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period, minimum 1.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: rising-edge clock.
- reset, in, 1: reset, asynchronous, active-low.
- digits_in, in, 4*DIGITS: BCD/hex nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is least significant.
- load, in, 1: capture digits_in and dp_in.
- blank_lz, in, 1: leading-zero suppression enable.
- blink_en, in, 1: blink whole display.
- dp_in, in, DIGITS: decimal point request per digit.
- seg_n, out, 7: active-low segments {g,f,e,d,c,b,a}.
- dp_n, out, 1: active-low decimal point.
- an_n, out, DIGITS: active-low digit enable, at most one bit low.
- frame_done, out, 1: one-cycle pulse per completed scan frame.

Function
REQ-003 The prescaler shall count 0..SCAN_DIV-1 and wrap to 0; tick = (prescaler == SCAN_DIV-1).
REQ-004 On each tick edge, digit index idx shall advance idx+1, and wrap from DIGITS-1 to 0.
REQ-005 On the tick edge where idx wraps to 0, frame_done shall be 1 in the following cycle only.
REQ-006 On an edge with load=1, data_reg shall capture digits_in and dp_reg shall capture dp_in; without load, both hold.
REQ-007 All outputs shall be registered and derived from the idx, data_reg, dp_reg and blink phase present before the edge, giving one cycle of latency from any idx or data_reg change.
REQ-008 load coincident with tick: idx and data_reg both update on the same edge; outputs show the new digit with the new data one cycle later.
REQ-009 Segment code per nibble (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E; blank=7F.
REQ-010 The active digit drives an_n bit idx low and all other bits high; seg_n shall carry the code of nibble idx.
REQ-011 dp_n = ~dp_reg[idx] when the digit is shown, and 1 when the digit is blanked.
REQ-012 Leading-zero blanking: when blank_lz=1, digit i>0 shall show seg_n=7F with dp_n=1 if nibbles DIGITS-1..i are all 0; an_n still selects the digit.
REQ-013 Leading-zero blanking never applies to digit 0; all-zero data shall display a single "0".
REQ-014 Leading-zero blanking stops at the first nonzero nibble, so interior zeros are shown (e.g. 0x0105 displays " 105").
REQ-015 Blink counter: while blink_en=1, a counter shall increment on each frame wrap; on reaching BLINK_FRAMES-1 it shall wrap to 0 and toggle the phase.
REQ-016 While blink_en=1 and phase=1, an_n shall be all ones, seg_n=7F and dp_n=1; scanning and frame_done continue unaffected.
REQ-017 With blink_en=0, the blink counter and phase shall be held at 0, so the display is always on.
REQ-018 When blink_en rises, the phase-0 (visible) half-period shall always come first.
REQ-019 The blink_en, blank_lz and dp_in inputs take effect on the next edge, with no synchronisation beyond one register stage; dp_in is sampled only on load.

Reset
REQ-020 reset low shall immediately force: seg_n=7F, dp_n=1, an_n all ones, frame_done=0.
REQ-021 reset low shall also clear prescaler, idx, data_reg, dp_reg, blink counter and phase to 0.
REQ-022 After reset release, the first output update shall occur at the first edge, showing digit 0 with value 0 (seg_n=40, an_n=...1110).
REQ-023 Reset asserted mid-frame shall abandon the scan; after release the scan restarts at idx 0 with the prescaler at 0.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-024 Scan order: load 0x1234, blank_lz=0.
- Required: an_n sequence 1110, 1101, 1011, 0111, each held 4 cycles.
- Required: seg_n sequence 19, 30, 24, 79.
- Required: frame_done pulses once every 16 cycles.
REQ-025 Leading zeros: load 0x0070, blank_lz=1.
- Required: digits 3 and 2 show seg_n=7F; digit 1 shows 78; digit 0 shows 40.
- Repeat with load 0x0000: only digit 0 shows 40.
REQ-026 Decimal point: load 0x00A5 with dp_in=0b0010 and blank_lz=1.
- Required: dp_n=0 only while an_n=1101.
- Required: digit 1 shows seg_n=08.
REQ-027 Blink: blink_en=1.
- Required: 32 cycles normal, then 32 cycles with an_n=1111 and seg_n=7F, repeating.
- Drop blink_en during the dark phase: display is visible from the next cycle.
REQ-028 Reset mid-operation: assert reset during idx=2.
- Required: outputs are 7F, 1111, 1 and frame_done=0 immediately.
- After release: digit 0 is shown with seg_n=40.
REQ-029 Load at tick: load 0x9999 on the same edge as the idx 0->1 tick.
- Required: digit 1 shows seg_n=10 from the next cycle.
